// File: rtl/rst_seq.sv
// Reset sequencer: qualifies N clock-lock inputs, stretches, then releases
// N_DOMAINS synchronous active-high resets in index order, re-asserting on lock loss or soft reset.
module rst_seq #(
    parameter int N_LOCKS   = 2,
    parameter int N_DOMAINS = 3,
    parameter int LOCK_FILT = 4,
    parameter int STRETCH   = 16,
    parameter int STAGGER   = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 wb_clk_o,
    input  logic                 async_rst_o,
    input  logic [N_LOCKS-1:0]   lock_i,
    input  logic                 soft_rst_i,
    output logic [N_DOMAINS-1:0] rst_o,
    output logic                 ready_o,
    output logic [2:0]           state_o,
    output logic [7:0]           relock_cnt_o
);

    localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd1,
        S_STRETCH   = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    state_t               state_q, state_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic [IDX_W-1:0]     idx_q, idx_n;
    logic [N_DOMAINS-1:0] rst_q, rst_n;
    logic                 rdy_q, rdy_n;
    logic [7:0]           rel_q, rel_n;
    logic [N_LOCKS-1:0]   sync1_q, sync2_q;
    logic                 all_locked;

    assign all_locked = &sync2_q;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        rst_n   = rst_q;
        rdy_n   = rdy_q;
        rel_n   = rel_q;
        case (state_q)
            S_WAIT_LOCK: begin
                rst_n = '1;
                rdy_n = 1'b0;
                idx_n = '0;
                if (!all_locked) begin
                    cnt_n = '0;
                end else if (cnt_q == CNT_W'(LOCK_FILT - 1)) begin
                    state_n = S_STRETCH;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            S_STRETCH, S_RELEASE, S_RUN: begin
                // Lock loss outranks a soft request and is the only event that is counted
                if (!all_locked) begin
                    state_n = S_WAIT_LOCK;
                    rst_n   = '1;
                    rdy_n   = 1'b0;
                    cnt_n   = '0;
                    idx_n   = '0;
                    if (rel_q != 8'hFF) rel_n = rel_q + 8'd1;
                end else if (soft_rst_i) begin
                    state_n = S_STRETCH;
                    rst_n   = '1;
                    rdy_n   = 1'b0;
                    cnt_n   = '0;
                    idx_n   = '0;
                end else if (state_q == S_STRETCH) begin
                    if (cnt_q == CNT_W'(STRETCH - 1)) begin
                        cnt_n    = '0;
                        rst_n[0] = 1'b0;
                        if (N_DOMAINS == 1) begin
                            state_n = S_RUN;
                            rdy_n   = 1'b1;
                        end else begin
                            state_n = S_RELEASE;
                            idx_n   = IDX_W'(1);
                        end
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end else if (state_q == S_RELEASE) begin
                    if (cnt_q == CNT_W'(STAGGER - 1)) begin
                        cnt_n = '0;
                        for (int k = 0; k < N_DOMAINS; k++)
                            if (k == int'(idx_q)) rst_n[k] = 1'b0;
                        if (idx_q == IDX_W'(N_DOMAINS - 1)) begin
                            state_n = S_RUN;
                            rdy_n   = 1'b1;
                        end else begin
                            idx_n = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_n = S_WAIT_LOCK;
                rst_n   = '1;
                rdy_n   = 1'b0;
                cnt_n   = '0;
                idx_n   = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_o or posedge async_rst_o) begin
        if (async_rst_o) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            rdy_q   <= 1'b0;
            rel_q   <= '0;
        end else begin
            sync1_q <= lock_i;
            sync2_q <= sync1_q;
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            rst_q   <= rst_n;
            rdy_q   <= rdy_n;
            rel_q   <= rel_n;
        end
    end

    assign rst_o        = rst_q;
    assign ready_o      = rdy_q;
    assign state_o      = state_q;
    assign relock_cnt_o = rel_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: power-up timing, lock glitch, loss in RUN, soft reset,
// simultaneous events, relock saturation and async reset mid-release.
module tb_rst_seq;

    logic       wb_clk_o = 1'b0;
    logic       async_rst_o = 1'b1;
    logic [1:0] lock_i = 2'b11;
    logic       soft_rst_i = 1'b0;
    logic [2:0] rst_o;
    logic       ready_o;
    logic [2:0] state_o;
    logic [7:0] relock_cnt_o;

    int checks = 0;
    int errors = 0;
    int e = 0;

    rst_seq #(.N_LOCKS(2), .N_DOMAINS(3), .LOCK_FILT(4), .STRETCH(16), .STAGGER(8), .CNT_W(16)) dut (
        .wb_clk_o(wb_clk_o), .async_rst_o(async_rst_o), .lock_i(lock_i), .soft_rst_i(soft_rst_i),
        .rst_o(rst_o), .ready_o(ready_o), .state_o(state_o), .relock_cnt_o(relock_cnt_o)
    );

    always #5 wb_clk_o = ~wb_clk_o;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One rising edge, then park on the following falling edge for sampling/driving
    task automatic step();
        @(posedge wb_clk_o);
        e++;
        @(negedge wb_clk_o);
    endtask

    task automatic step_to(input int tgt);
        while (e < tgt) step();
    endtask

    initial begin
        logic [2:0] exp_rst;
        logic [2:0] exp_st;

        // Power-up: lock already high while in reset
        repeat (2) @(negedge wb_clk_o);
        chk("rst_por", rst_o, 3'b111);
        chk("rdy_por", ready_o, 1'b0);
        chk("st_por", state_o, 3'd1);
        chk("rel_por", relock_cnt_o, 8'd0);
        async_rst_o = 1'b0;
        e = -1;
        for (int i = 0; i <= 40; i++) begin
            step();
            exp_rst = {e < 37, e < 29, e < 21};
            exp_st  = (e < 5) ? 3'd1 : (e < 21) ? 3'd2 : (e < 37) ? 3'd3 : 3'd4;
            chk($sformatf("pu_rst_E%0d", e), rst_o, exp_rst);
            chk($sformatf("pu_st_E%0d", e), state_o, exp_st);
            chk($sformatf("pu_rdy_E%0d", e), ready_o, e >= 37);
        end
        chk("pu_rel", relock_cnt_o, 8'd0);

        // Lock glitch during filtering restarts the filter
        async_rst_o = 1'b1;
        #1;
        chk("gl_rst_async", rst_o, 3'b111);
        async_rst_o = 1'b0;
        e = -1;
        step_to(1);
        lock_i = 2'b01;
        step_to(2);
        lock_i = 2'b11;
        step_to(7);
        chk("gl_st_E7", state_o, 3'd1);
        step_to(8);
        chk("gl_st_E8", state_o, 3'd2);
        step_to(23);
        chk("gl_rst_E23", rst_o, 3'b111);
        step_to(24);
        chk("gl_rst_E24", rst_o, 3'b110);
        chk("gl_rel", relock_cnt_o, 8'd0);
        step_to(40);
        chk("gl_rdy_E40", ready_o, 1'b1);
        chk("gl_st_E40", state_o, 3'd4);

        // Loss in RUN for 3 cycles
        e = 0;
        lock_i = 2'b10;
        step_to(2);
        chk("lr_rst_A2", rst_o, 3'b000);
        step_to(3);
        lock_i = 2'b11;
        chk("lr_rst_A3", rst_o, 3'b111);
        chk("lr_rdy_A3", ready_o, 1'b0);
        chk("lr_rel_A3", relock_cnt_o, 8'd1);
        chk("lr_st_A3", state_o, 3'd1);
        step_to(24);
        chk("lr_rst_A24", rst_o, 3'b111);
        step_to(25);
        chk("lr_rst_A25", rst_o, 3'b110);
        step_to(33);
        chk("lr_rst_A33", rst_o, 3'b100);
        step_to(41);
        chk("lr_rst_A41", rst_o, 3'b000);
        chk("lr_rdy_A41", ready_o, 1'b1);

        // Soft reset pulse in RUN
        e = 0;
        soft_rst_i = 1'b1;
        step_to(1);
        soft_rst_i = 1'b0;
        chk("sr_rst_B1", rst_o, 3'b111);
        chk("sr_st_B1", state_o, 3'd2);
        chk("sr_rdy_B1", ready_o, 1'b0);
        chk("sr_rel_B1", relock_cnt_o, 8'd1);
        step_to(16);
        chk("sr_rst_B16", rst_o, 3'b111);
        step_to(17);
        chk("sr_rst_B17", rst_o, 3'b110);
        chk("sr_st_B17", state_o, 3'd3);

        // Lock loss and soft request reach the FSM together in RELEASE
        step_to(18);
        lock_i = 2'b00;
        step_to(20);
        chk("sim_st_B20", state_o, 3'd3);
        soft_rst_i = 1'b1;
        step_to(21);
        soft_rst_i = 1'b0;
        chk("sim_st_B21", state_o, 3'd1);
        chk("sim_rel_B21", relock_cnt_o, 8'd2);
        chk("sim_rst_B21", rst_o, 3'b111);

        // Saturation: 254 more losses, each reaching STRETCH first
        for (int i = 0; i < 254; i++) begin
            lock_i = 2'b11;
            repeat (6) step();
            lock_i = 2'b00;
            repeat (3) step();
            if (i == 252) chk("sat_255", relock_cnt_o, 8'd255);
        end
        chk("sat_hold", relock_cnt_o, 8'd255);
        chk("sat_st", state_o, 3'd1);

        // Async reset mid-RELEASE
        lock_i = 2'b11;
        e = 0;
        step_to(30);
        chk("ar_rst_C30", rst_o, 3'b100);
        async_rst_o = 1'b1;
        #1;
        chk("ar_rst_async", rst_o, 3'b111);
        chk("ar_st_async", state_o, 3'd1);
        chk("ar_rdy_async", ready_o, 1'b0);
        chk("ar_rel_async", relock_cnt_o, 8'd0);
        #1;
        async_rst_o = 1'b0;
        e = -1;
        step_to(20);
        chk("ar_rst_E20", rst_o, 3'b111);
        step_to(21);
        chk("ar_rst_E21", rst_o, 3'b110);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
